// File: rtl/fft_link_host.sv
// Host-side UART link to an FFT engine: streams a sample frame out, then collects the result words.
// One transaction per i_start; result read port has 1-cycle latency; no backpressure, o_busy blocks writes/starts.
module fft_link_host #(
    parameter int FFT_SIZE      = 32,
    parameter int WORD_SIZE     = 16,
    parameter int DATA_LENGTH   = 8,
    parameter int CLOCK_PER_BIT = 434,
    parameter int TIMEOUT_CLKS  = 2**20
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [$clog2(FFT_SIZE)-1:0]  i_wr_addr,
    input  logic [DATA_LENGTH-1:0]       i_wr_data,
    input  logic                         i_start,
    input  logic [$clog2(FFT_SIZE)-1:0]  i_rd_addr,
    output logic [WORD_SIZE-1:0]         o_rd_data,
    output logic                         o_TX_bit,
    input  logic                         i_RX_bit,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_timeout_err,
    output logic                         o_frame_err
);

    localparam int AW     = $clog2(FFT_SIZE);
    localparam int NBYTES = 2 * FFT_SIZE;
    localparam int BCW    = $clog2(NBYTES);
    localparam int CW     = $clog2(CLOCK_PER_BIT + 1);
    localparam int BW     = $clog2(DATA_LENGTH + 2);
    localparam int DW     = $clog2(DATA_LENGTH);
    localparam int TW     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0]  BIT_LAST    = CW'(CLOCK_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST   = CW'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]  DATA_LAST   = BW'(DATA_LENGTH);
    localparam logic [BW-1:0]  STOP_IDX    = BW'(DATA_LENGTH + 1);
    localparam logic [AW-1:0]  LAST_SAMPLE = AW'(FFT_SIZE - 1);
    localparam logic [BCW-1:0] LAST_BYTE   = BCW'(NBYTES - 1);
    localparam logic [TW-1:0]  TO_LAST     = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RX, RECV, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_LENGTH-1:0] samples [FFT_SIZE];
    logic [WORD_SIZE-1:0]   words   [FFT_SIZE];

    logic           tx_line;
    logic [CW-1:0]  tx_cnt;
    logic [BW-1:0]  tx_bit;
    logic [AW-1:0]  tx_byte;
    logic           tx_end;

    logic                   rx_s1, rx_s2, rx_prev;
    logic                   rx_active;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_bit;
    logic [DATA_LENGTH-1:0] rx_shift;
    logic [BCW-1:0]         rx_byte_cnt;
    logic [TW-1:0]          to_cnt;

    logic rx_en, rx_fall, rx_tick, start_ok, stop_tick, frame_bad, byte_ok, to_hit;

    assign o_TX_bit = tx_line;

    assign tx_end    = (state == SEND) && (tx_cnt == BIT_LAST) && (tx_bit == STOP_IDX)
                       && (tx_byte == LAST_SAMPLE);
    assign rx_en     = (state == WAIT_RX) || (state == RECV);
    // Edge needs a high-to-low step on the synchronized line; rx_prev resets low so a stuck-low line never starts.
    assign rx_fall   = rx_prev && !rx_s2;
    assign rx_tick   = rx_active && (rx_cnt == ((rx_bit == '0) ? HALF_LAST : BIT_LAST));
    assign start_ok  = rx_tick && (rx_bit == '0) && !rx_s2;
    assign stop_tick = rx_tick && (rx_bit == STOP_IDX);
    assign frame_bad = stop_tick && !rx_s2;
    assign byte_ok   = stop_tick && rx_s2;
    assign to_hit    = rx_en && !rx_active && !rx_fall && (to_cnt == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_busy    = (state != IDLE);
        o_done    = 1'b0;
        case (state)
            IDLE:    if (i_start) state_nxt = SEND;
            SEND:    if (tx_end) state_nxt = WAIT_RX;
            WAIT_RX: begin
                if (to_hit)        state_nxt = IDLE;
                else if (start_ok) state_nxt = RECV;
            end
            RECV: begin
                if (to_hit || frame_bad)                          state_nxt = IDLE;
                else if (byte_ok && (rx_byte_cnt == LAST_BYTE))   state_nxt = DONE;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample buffer survives reset on purpose so a frame can be resent after an abort.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (state == IDLE)) samples[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_line <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else if (state == SEND) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == STOP_IDX) begin
                    tx_bit  <= '0;
                    tx_line <= (tx_byte == LAST_SAMPLE);
                    tx_byte <= tx_byte + 1'b1;
                end else begin
                    tx_bit  <= tx_bit + 1'b1;
                    tx_line <= (tx_bit == DATA_LAST) ? 1'b1 : samples[tx_byte][tx_bit[DW-1:0]];
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end else begin
            tx_line <= !((state == IDLE) && i_start);
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_s1       <= 1'b0;
            rx_s2       <= 1'b0;
            rx_prev     <= 1'b0;
            rx_active   <= 1'b0;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_byte_cnt <= '0;
            to_cnt      <= '0;
            for (int i = 0; i < FFT_SIZE; i++) words[i] <= '0;
        end else begin
            rx_s1   <= i_RX_bit;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (!rx_en) begin
                rx_active   <= 1'b0;
                rx_cnt      <= '0;
                rx_bit      <= '0;
                rx_byte_cnt <= '0;
                to_cnt      <= '0;
            end else if (!rx_active) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                if (rx_fall) begin
                    rx_active <= 1'b1;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else if (rx_tick) begin
                rx_cnt <= '0;
                if (rx_bit == '0) begin
                    // A high start sample is a glitch: drop it and wait for the next edge.
                    if (rx_s2) rx_active <= 1'b0;
                    else       rx_bit    <= 1'b1;
                end else if (rx_bit == STOP_IDX) begin
                    rx_active <= 1'b0;
                    rx_bit    <= '0;
                    if (rx_s2) begin
                        if (rx_byte_cnt[0])
                            words[rx_byte_cnt[BCW-1:1]][DATA_LENGTH +: DATA_LENGTH] <= rx_shift;
                        else
                            words[rx_byte_cnt[BCW-1:1]][0 +: DATA_LENGTH] <= rx_shift;
                        rx_byte_cnt <= rx_byte_cnt + 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[DATA_LENGTH-1:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_timeout_err <= 1'b0;
            o_frame_err   <= 1'b0;
        end else if ((state == IDLE) && i_start) begin
            o_timeout_err <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            if (to_hit)                         o_timeout_err <= 1'b1;
            if (frame_bad && (state == RECV))   o_frame_err   <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_rd_data <= '0;
        else          o_rd_data <= words[i_rd_addr];
    end

endmodule

// File: tb/tb_fft_link_host.sv
// Self-checking bench for fft_link_host with a fast UART (4 clocks/bit) and a short response timeout.
module tb_fft_link_host;

    localparam int CPB = 4;
    localparam int TO  = 200;
    localparam int N   = 32;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_wr_en, i_start, i_RX_bit;
    logic [4:0]  i_wr_addr, i_rd_addr;
    logic [7:0]  i_wr_data;
    logic [15:0] o_rd_data;
    logic        o_TX_bit, o_busy, o_done, o_timeout_err, o_frame_err;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    logic [7:0]  smp [N];
    logic [7:0]  tx_q [$];
    logic [15:0] rd_q [$];

    fft_link_host #(
        .FFT_SIZE(N), .WORD_SIZE(16), .DATA_LENGTH(8),
        .CLOCK_PER_BIT(CPB), .TIMEOUT_CLKS(TO)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_start(i_start), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_TX_bit(o_TX_bit), .i_RX_bit(i_RX_bit), .o_busy(o_busy), .o_done(o_done),
        .o_timeout_err(o_timeout_err), .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_done) done_pulses <= done_pulses + 1;

    task automatic do_reset(input logic rx_level);
        i_RX_bit = rx_level;
        i_rst_n  = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Called at the negedge after the start edge; walks all 32 characters cycle by cycle.
    task automatic check_tx_frames();
        for (int c = 0; c < N; c++) begin
            logic [7:0] exp_b, obs_b;
            logic       ok, exp_bit;
            exp_b = tx_q.pop_front();
            obs_b = '0;
            ok    = 1'b1;
            for (int b = 0; b < 10; b++) begin
                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                for (int r = 0; r < CPB; r++) begin
                    if (o_TX_bit !== exp_bit) ok = 1'b0;
                    if (r == CPB/2 && b >= 1 && b <= 8) obs_b[b-1] = o_TX_bit;
                    @(negedge i_clk);
                end
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL tx_char%0d got 0x%h want 0x%h (or framing/timing off)", c, obs_b, exp_b);
            end
        end
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic stop);
        i_RX_bit = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int b = 0; b < 8; b++) begin
            i_RX_bit = d[b];
            repeat (CPB) @(negedge i_clk);
        end
        i_RX_bit = stop;
        repeat (CPB) @(negedge i_clk);
        i_RX_bit = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic read_check(input int a);
        logic [15:0] exp_w;
        i_rd_addr = 5'(a);
        @(negedge i_clk);
        exp_w = rd_q.pop_front();
        total++;
        if (o_rd_data !== exp_w) begin
            bad++;
            $display("FAIL rd_word%0d got 0x%h want 0x%h", a, o_rd_data, exp_w);
        end
    endtask

    task automatic test_reset();
        i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0; i_start = 0; i_rd_addr = 0;
        do_reset(1'b0);
        total++; if (o_TX_bit !== 1'b1)      begin bad++; $display("FAIL rst_tx got %b want 1", o_TX_bit); end
        total++; if (o_busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0)        begin bad++; $display("FAIL rst_done got %b want 0", o_done); end
        total++; if (o_timeout_err !== 1'b0) begin bad++; $display("FAIL rst_tmo got %b want 0", o_timeout_err); end
        total++; if (o_frame_err !== 1'b0)   begin bad++; $display("FAIL rst_frm got %b want 0", o_frame_err); end
        total++; if (o_rd_data !== 16'h0)    begin bad++; $display("FAIL rst_rd got 0x%h want 0x0000", o_rd_data); end
    endtask

    // Line is held low since reset: no false start may occur, so timeout lands exactly on schedule.
    task automatic test_send_timeout();
        int n, d0;
        for (int i = 0; i < N; i++) begin
            i_wr_en = 1; i_wr_addr = 5'(i); i_wr_data = 8'(i); smp[i] = 8'(i);
            @(negedge i_clk);
        end
        i_wr_en = 0;
        for (int i = 0; i < N; i++) tx_q.push_back(smp[i]);
        d0 = done_pulses;
        pulse_start();
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL send_busy got %b want 1", o_busy); end
        check_tx_frames();
        total++; if (o_TX_bit !== 1'b1) begin bad++; $display("FAIL wait_tx_idle got %b want 1", o_TX_bit); end
        total++; if (o_busy !== 1'b1)   begin bad++; $display("FAIL wait_busy got %b want 1", o_busy); end
        n = 32 * 10 * CPB;
        while (!o_timeout_err && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        total++; if (n != 32*10*CPB + TO) begin bad++; $display("FAIL tmo_cycle got %0d want %0d", n, 32*10*CPB + TO); end
        total++; if (o_busy !== 1'b0)      begin bad++; $display("FAIL tmo_busy got %b want 0", o_busy); end
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL tmo_frm got %b want 0", o_frame_err); end
        total++; if (done_pulses != d0)    begin bad++; $display("FAIL tmo_done got %0d want 0", done_pulses - d0); end
        i_RX_bit = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_loopback();
        int d0;
        logic [7:0] lo, hi;
        pulse_start();
        repeat (100) @(negedge i_clk);
        rx_byte(8'hAA, 1'b1);
        repeat (1150) @(negedge i_clk);
        d0 = done_pulses;
        for (int w = 0; w < N; w++) begin
            lo = 8'(8'h34 + w);
            hi = 8'(8'h12 + w);
            rd_q.push_back({hi, lo});
            rx_byte(lo, 1'b1);
            rx_byte(hi, 1'b1);
        end
        repeat (3) @(negedge i_clk);
        total++; if (done_pulses - d0 != 1)   begin bad++; $display("FAIL lb_done got %0d pulses want 1", done_pulses - d0); end
        total++; if (o_busy !== 1'b0)         begin bad++; $display("FAIL lb_busy got %b want 0", o_busy); end
        total++; if (o_timeout_err !== 1'b0)  begin bad++; $display("FAIL lb_tmo got %b want 0", o_timeout_err); end
        total++; if (o_frame_err !== 1'b0)    begin bad++; $display("FAIL lb_frm got %b want 0", o_frame_err); end
        for (int w = 0; w < N; w++) read_check(w);
    endtask

    task automatic test_frame_err();
        int d0;
        do_reset(1'b1);
        d0 = done_pulses;
        pulse_start();
        repeat (1290) @(negedge i_clk);
        for (int b = 0; b < 6; b++) rx_byte(8'(8'h40 + b), (b != 5));
        rd_q.push_back(16'h4140);
        rd_q.push_back(16'h4342);
        rd_q.push_back(16'h0044);
        for (int w = 3; w < N; w++) rd_q.push_back(16'h0000);
        total++; if (o_frame_err !== 1'b1)   begin bad++; $display("FAIL fe_flag got %b want 1", o_frame_err); end
        total++; if (o_busy !== 1'b0)        begin bad++; $display("FAIL fe_busy got %b want 0", o_busy); end
        total++; if (o_timeout_err !== 1'b0) begin bad++; $display("FAIL fe_tmo got %b want 0", o_timeout_err); end
        total++; if (done_pulses != d0)      begin bad++; $display("FAIL fe_done got %0d want 0", done_pulses - d0); end
        for (int w = 0; w < N; w++) read_check(w);
    endtask

    task automatic test_glitch();
        int n, d0;
        do_reset(1'b1);
        d0 = done_pulses;
        pulse_start();
        repeat (1290) @(negedge i_clk);
        i_RX_bit = 1'b0;
        @(negedge i_clk);
        i_RX_bit = 1'b1;
        repeat (6) @(negedge i_clk);
        rx_byte(8'h5A, 1'b1);
        rd_q.push_back(16'h005A);
        rd_q.push_back(16'h0000);
        read_check(0);
        read_check(1);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL gl_busy got %b want 1", o_busy); end
        n = 0;
        while (o_busy && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        total++; if (o_timeout_err !== 1'b1) begin bad++; $display("FAIL gl_tmo got %b want 1 after %0d cycles", o_timeout_err, n); end
        total++; if (o_frame_err !== 1'b0)   begin bad++; $display("FAIL gl_frm got %b want 0", o_frame_err); end
        total++; if (done_pulses != d0)      begin bad++; $display("FAIL gl_done got %0d want 0", done_pulses - d0); end
    endtask

    task automatic test_reset_mid_send();
        do_reset(1'b1);
        // Write on the start cycle is accepted; a write during SEND is not.
        i_start = 1; i_wr_en = 1; i_wr_addr = 5; i_wr_data = 8'hC3; smp[5] = 8'hC3;
        @(negedge i_clk);
        i_start = 0; i_wr_en = 0;
        repeat (49) @(negedge i_clk);
        i_wr_en = 1; i_wr_addr = 0; i_wr_data = 8'hFF;
        @(negedge i_clk);
        i_wr_en = 0;
        repeat (359) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        total++; if (o_TX_bit !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got %b want 1", o_TX_bit); end
        total++; if (o_busy !== 1'b0)   begin bad++; $display("FAIL mid_rst_busy got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0)   begin bad++; $display("FAIL mid_rst_done got %b want 0", o_done); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < N; i++) tx_q.push_back(smp[i]);
        pulse_start();
        check_tx_frames();
        do_reset(1'b1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_RX_bit = 1'b0;
        test_reset();
        test_send_timeout();
        test_loopback();
        test_frame_err();
        test_glitch();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
